// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler that owns the select pins of a shared 16:1 mux.
// It grants one requester, waits SETTLE cycles for the mux to settle, then holds valid until ack or withdrawal.
module mux16_rr_sched #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ack,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  ptr_r;
  logic [3:0]  ptr_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_s;
  logic [15:0] gnt_r;
  logic [15:0] gnt_s;
  logic        valid_r;
  logic        valid_s;
  logic [31:0] dbl_s;
  logic [15:0] rot_s;
  logic [3:0]  win_s;
  logic        req_w_s;

  // Position of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        pos = 4'(i);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  // Rotate req so the pointer lands on bit 0, then the lowest set bit is the circular winner.
  always_comb begin
    dbl_s   = {req, req};
    rot_s   = dbl_s[{1'b0, ptr_r} +: 16];
    win_s   = ptr_r + lowest_set(rot_s);
    req_w_s = req[idx_r];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; en only gates leaving IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en && (req != 16'd0)) begin
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!req_w_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_s = ST_VALID;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_VALID: begin
        if (ack || !req_w_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_VALID;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of pointer, counter and registered outputs.
  always_comb begin
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    gnt_s   = gnt_r;
    valid_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        valid_s = 1'b0;
        if (state_s == ST_SETTLE) begin
          idx_s = win_s;
          gnt_s = 16'd1 << win_s;
          cnt_s = SETTLE_M1;
        end else begin
          gnt_s = 16'd0;
        end
      end
      ST_SETTLE: begin
        if (state_s == ST_IDLE) begin
          gnt_s = 16'd0;
          ptr_s = idx_r + 4'd1;
        end else if (state_s == ST_VALID) begin
          valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_VALID: begin
        if (state_s == ST_IDLE) begin
          valid_s = 1'b0;
          gnt_s   = 16'd0;
          ptr_s   = idx_r + 4'd1;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        gnt_s   = 16'd0;
        valid_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; the select pins only load on a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= 4'd0;
      cnt_r   <= 4'd0;
      idx_r   <= 4'd0;
      gnt_r   <= 16'd0;
      valid_r <= 1'b0;
    end else begin
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      gnt_r   <= gnt_s;
      valid_r <= valid_s;
    end
  end

  assign s2      = idx_r[3];
  assign s3      = idx_r[2];
  assign s0      = idx_r[1];
  assign s1      = idx_r[0];
  assign gnt_idx = idx_r;
  assign gnt     = gnt_r;
  assign valid   = valid_r;
  assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched: the driver predicts each winner from a round-robin model,
// and a monitor checks every grant episode (select encoding, settle latency, release, spacing).
module tb_mux16_rr_sched;

  localparam int SETTLE = 2;
  localparam int BOUND  = 40;

  typedef struct {
    logic [3:0] idx;
    int         mode;   // 0 ack, 1 withdraw in SETTLE, 2 withdraw in VALID, 3 reset in VALID
    bit         b2b;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        ack   = 1'b0;
  logic [15:0] req   = 16'd0;
  logic        s0, s1, s2, s3;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        valid;
  logic        busy;
  logic [3:0]  sel;

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   rst_count = 0;
  int   m_ptr     = 0;
  exp_t exp_q[$];

  mux16_rr_sched #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .gnt(gnt), .gnt_idx(gnt_idx), .valid(valid), .busy(busy)
  );

  assign sel = {s2, s3, s0, s1};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0h, expected %0h", name, got, want);
    else n_pass++;
  endtask

  // First requester at or after the pointer, scanning circularly.
  function automatic int model_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return 0;
  endfunction

  // Called at a negedge; returns at a negedge with the grant released.
  task automatic do_txn(input logic [15:0] r, input int mode, input int hold, input bit b2b);
    int   w;
    int   n;
    exp_t e;
    w     = model_winner(r, m_ptr);
    req   = r;
    en    = 1'b1;
    e.idx = 4'(w);
    e.mode = mode;
    e.b2b = b2b;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 16'd0 && n < BOUND);
    chk("grant_timeout", 32'(gnt != 16'd0), 32'd1);
    if (gnt == 16'd0) begin
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      en = 1'b0;
      return;
    end
    en = 1'b0;
    if (mode == 1) begin
      req = r & ~(16'd1 << w);
    end else begin
      n = 0;
      while (valid !== 1'b1 && n < BOUND) begin
        if (mode == 0) ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      ack = 1'b0;
      chk("valid_timeout", 32'(valid), 32'd1);
      if (mode == 3) begin
        #2 rst_n = 1'b0;
        rst_count++;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;
        m_ptr = 0;
        req   = 16'd0;
        @(negedge clk);
        return;
      end else if (mode == 2) begin
        req = r & ~(16'd1 << w);
      end else begin
        repeat (hold) begin
          @(negedge clk);
          chk("en_low_valid_hold", 32'(valid), 32'd1);
        end
        ack = 1'b1;
      end
    end
    n = 0;
    while (gnt != 16'd0 && n < BOUND) begin
      @(negedge clk);
      ack = 1'b0;
      n++;
    end
    ack = 1'b0;
    chk("release_timeout", 32'(gnt == 16'd0), 32'd1);
    m_ptr = (w + 1) % 16;
  endtask

  // Monitor: pops the expected winner at each new grant and follows the episode to release.
  initial begin : monitor
    int   cyc;
    int   rise;
    int   seen_rst;
    bit   in_ep;
    bit   v_seen;
    exp_t cur;
    cyc = 0; rise = 0; seen_rst = 0; in_ep = 1'b0; v_seen = 1'b0;
    cur.idx = 4'd0; cur.mode = 0; cur.b2b = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (seen_rst != rst_count) begin
        seen_rst = rst_count;
        in_ep = 1'b0;
      end else if (!rst_n) begin
        in_ep = 1'b0;
      end else if (!in_ep) begin
        if (gnt != 16'd0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(gnt), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("grant_idx", 32'(gnt_idx), 32'(cur.idx));
            chk("grant_onehot", 32'(gnt), 32'(16'd1 << cur.idx));
            chk("grant_sel", 32'(sel), 32'(cur.idx));
            chk("grant_busy", 32'(busy), 32'd1);
            chk("grant_valid_low", 32'(valid), 32'd0);
            if (cur.b2b) chk("b2b_spacing", 32'(cyc - rise), 32'(SETTLE + 2));
            rise = cyc; in_ep = 1'b1; v_seen = 1'b0;
          end
        end else begin
          chk("idle_busy", 32'(busy), 32'd0);
          chk("idle_valid", 32'(valid), 32'd0);
        end
      end else if (gnt != 16'd0) begin
        chk("hold_gnt", 32'(gnt), 32'(16'd1 << cur.idx));
        chk("hold_sel", 32'(sel), 32'(cur.idx));
        chk("hold_busy", 32'(busy), 32'd1);
        if (v_seen) begin
          chk("valid_stays", 32'(valid), 32'd1);
        end else if (valid) begin
          v_seen = 1'b1;
          chk("valid_latency", 32'(cyc - rise), 32'(SETTLE));
          chk("valid_after_withdraw", 32'(cur.mode != 1), 32'd1);
        end
      end else begin
        in_ep = 1'b0;
        chk("release_valid", 32'(valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_sel", 32'(sel), 32'(cur.idx));
        chk("release_idx", 32'(gnt_idx), 32'(cur.idx));
        chk("valid_seen", 32'(v_seen), 32'(cur.mode != 1));
      end
    end
  end

  initial begin : driver
    logic [15:0] r;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Channel 9 reaches VALID, then an asynchronous reset pulse lands between edges.
    do_txn(16'h0200, 3, 0, 1'b0);

    // Full load from a reset pointer: 0..15, 0, 1 at minimum spacing.
    for (int i = 0; i < 18; i++) do_txn(16'hFFFF, 0, 0, i > 0);

    do_txn(16'h0020, 0, 0, 1'b0);
    do_txn(16'h2000, 0, 0, 1'b0);
    do_txn(16'h8008, 0, 0, 1'b0);
    do_txn(16'h8008, 0, 0, 1'b0);
    do_txn(16'hFFFF, 0, 0, 1'b0);

    do_txn(16'h0080, 1, 0, 1'b0);
    do_txn(16'hFFFF, 0, 0, 1'b0);

    // Enable gating, with stray ack pulses that must be ignored in IDLE.
    en  = 1'b0;
    req = 16'h0001;
    repeat (20) begin
      ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("gate_no_grant", 32'(gnt), 32'd0);
    end
    ack = 1'b0;
    do_txn(16'h0001, 0, 3, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("gate_after_release", 32'(gnt), 32'd0);
    end

    for (int i = 0; i < 80; i++) begin
      r = 16'($urandom);
      if (r == 16'd0) r = 16'h0001;
      en = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(r, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    en  = 1'b0;
    req = 16'd0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
